// File: rtl/core_ex_lsu_wbck.sv
// Writeback stage after the LSU: buffers load results in a small in-order FIFO and
// shares the single register-file write port with the ALU under a two-state priority FSM.
module core_ex_lsu_wbck #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic              i_lsu_is_load,
  input  logic [RIDX_W-1:0] i_lsu_rd_idx,
  input  logic [XLEN-1:0]   i_lsu_rdata,
  input  logic              i_lsu_unalign,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [RIDX_W-1:0] i_alu_rd_idx,
  input  logic [XLEN-1:0]   i_alu_wdata,
  output logic              o_rf_wen,
  output logic [RIDX_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata,
  input  logic [RIDX_W-1:0] i_chk_rs1,
  input  logic [RIDX_W-1:0] i_chk_rs2,
  output logic              o_hazard,
  output logic              o_excp_valid,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {ALU_PRI, LSU_PRI} arb_e;

  arb_e                         state_q, state_d;
  logic [PW:0]                  cnt_q, cnt_d;
  logic [PW-1:0]                rptr_q, wptr_q;
  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][RIDX_W-1:0] rd_q;
  logic [DEPTH-1:0][XLEN-1:0]   data_q;
  logic                         rf_wen_q, excp_q, ovf_q;
  logic [RIDX_W-1:0]            rf_waddr_q;
  logic [XLEN-1:0]              rf_wdata_q;

  logic full, nonempty, lsu_ld, enq, alu_req, gnt_alu, gnt_lsu, hz;

  assign full     = (cnt_q == FULL);
  assign nonempty = (cnt_q != '0);
  assign lsu_ld   = i_lsu_valid & i_lsu_is_load & (i_lsu_rd_idx != '0);
  // Full blocks enqueue even if the head drains this cycle.
  assign enq      = lsu_ld & ~full;
  assign alu_req  = i_alu_valid & (i_alu_rd_idx != '0);

  always_comb begin
    gnt_alu     = 1'b0;
    gnt_lsu     = 1'b0;
    o_alu_ready = 1'b0;
    if (state_q == ALU_PRI) begin
      o_alu_ready = i_alu_valid;
      gnt_alu     = alu_req;
      gnt_lsu     = ~alu_req & nonempty;
    end else begin
      gnt_lsu     = nonempty;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({enq, gnt_lsu})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    state_d = state_q;
    if (state_q == ALU_PRI && full)               state_d = LSU_PRI;
    else if (state_q == LSU_PRI && cnt_d == '0)   state_d = ALU_PRI;
  end

  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && ((i_chk_rs1 != '0 && rd_q[i] == i_chk_rs1) ||
                       (i_chk_rs2 != '0 && rd_q[i] == i_chk_rs2)))
        hz = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALU_PRI;
      cnt_q      <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      vld_q      <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      excp_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt_lsu) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      if (enq) begin
        vld_q[wptr_q]  <= 1'b1;
        rd_q[wptr_q]   <= i_lsu_rd_idx;
        data_q[wptr_q] <= i_lsu_rdata;
        wptr_q         <= wptr_q + PW'(1);
      end
      rf_wen_q <= gnt_alu | gnt_lsu;
      if (gnt_alu) begin
        rf_waddr_q <= i_alu_rd_idx;
        rf_wdata_q <= i_alu_wdata;
      end else if (gnt_lsu) begin
        rf_waddr_q <= rd_q[rptr_q];
        rf_wdata_q <= data_q[rptr_q];
      end
      excp_q <= i_lsu_valid & ~i_lsu_is_load & i_lsu_unalign;
      if (lsu_ld & full) ovf_q <= 1'b1;
    end
  end

  assign o_lsu_ready  = ~full;
  assign o_busy       = nonempty;
  assign o_hazard     = hz;
  assign o_rf_wen     = rf_wen_q;
  assign o_rf_waddr   = rf_waddr_q;
  assign o_rf_wdata   = rf_wdata_q;
  assign o_excp_valid = excp_q;
  assign o_overflow   = ovf_q;
endmodule

// File: tb/tb_core_ex_lsu_wbck.sv
// Directed bench for core_ex_lsu_wbck: expected register-file writes are queued at
// grant time and a negedge monitor pops and compares each presented write.
module tb_core_ex_lsu_wbck;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_lsu_valid = 0, i_lsu_is_load = 0, i_lsu_unalign = 0;
  logic [4:0]  i_lsu_rd_idx = 0, i_alu_rd_idx = 0, i_chk_rs1 = 0, i_chk_rs2 = 0;
  logic [31:0] i_lsu_rdata = 0, i_alu_wdata = 0;
  logic        i_alu_valid = 0;
  logic        o_lsu_ready, o_alu_ready, o_rf_wen, o_hazard, o_excp_valid, o_overflow, o_busy;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;

  int total = 0, bad = 0;
  logic [36:0] expq[$];

  core_ex_lsu_wbck #(.XLEN(32), .RIDX_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_is_load(i_lsu_is_load),
    .i_lsu_rd_idx(i_lsu_rd_idx), .i_lsu_rdata(i_lsu_rdata), .i_lsu_unalign(i_lsu_unalign),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_rd_idx(i_alu_rd_idx),
    .i_alu_wdata(i_alu_wdata), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata), .i_chk_rs1(i_chk_rs1), .i_chk_rs2(i_chk_rs2),
    .o_hazard(o_hazard), .o_excp_valid(o_excp_valid), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    i_alu_valid = v; i_alu_rd_idx = rd; i_alu_wdata = d;
  endtask

  task automatic lsu(input logic v, input logic ld, input logic [4:0] rd,
                     input logic [31:0] d, input logic un);
    i_lsu_valid = v; i_lsu_is_load = ld; i_lsu_rd_idx = rd; i_lsu_rdata = d; i_lsu_unalign = un;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    expq.push_back({a, d});
  endtask

  // Monitor: every presented write must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [36:0] e;
    if (o_rf_wen) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", o_rf_waddr, o_rf_wdata);
      end else begin
        e = expq.pop_front();
        chk("rf_waddr", 64'(o_rf_waddr), 64'(e[36:32]));
        chk("rf_wdata", 64'(o_rf_wdata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    tick(); tick();
    rst = 0;
    // Reset state
    chk("rst_wen", 64'(o_rf_wen), 0);
    chk("rst_waddr", 64'(o_rf_waddr), 0);
    chk("rst_wdata", 64'(o_rf_wdata), 0);
    chk("rst_excp", 64'(o_excp_valid), 0);
    chk("rst_ovf", 64'(o_overflow), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_lsu_ready", 64'(o_lsu_ready), 1);

    // Single load: write appears exactly two cycles after the pulse
    lsu(1, 1, 5, 32'hDEADBEEF, 0); push(5, 32'hDEADBEEF);
    tick(); lsu(0, 0, 0, 0, 0);
    chk("ld_wen_n1", 64'(o_rf_wen), 0);
    chk("ld_busy_n1", 64'(o_busy), 1);
    tick();
    chk("ld_wen_n2", 64'(o_rf_wen), 1);
    chk("ld_busy_n2", 64'(o_busy), 0);
    tick(); tick();

    // Contention: ALU saturates until FIFO fills, then loads drain in order
    alu(1, 7, 32'h22); lsu(1, 1, 3, 32'h11, 0); #1;
    chk("ct_alu_rdy0", 64'(o_alu_ready), 1); push(7, 32'h22);
    tick(); lsu(1, 1, 6, 32'h33, 0); #1;
    chk("ct_alu_rdy1", 64'(o_alu_ready), 1); push(7, 32'h22);
    tick(); lsu(0, 0, 0, 0, 0); #1;
    chk("ct_lsu_rdy_full", 64'(o_lsu_ready), 0);
    chk("ct_alu_rdy2", 64'(o_alu_ready), 1); push(7, 32'h22);
    tick();
    chk("ct_alu_rdy3", 64'(o_alu_ready), 0); push(3, 32'h11);
    tick();
    chk("ct_alu_rdy4", 64'(o_alu_ready), 0); push(6, 32'h33);
    tick();
    chk("ct_alu_rdy5", 64'(o_alu_ready), 1); push(7, 32'h22);
    tick(); alu(0, 0, 0); tick(); tick();

    // Overflow: third load is dropped while full, flag is sticky
    alu(1, 7, 32'h22); lsu(1, 1, 1, 32'h1, 0); push(7, 32'h22);
    tick(); lsu(1, 1, 2, 32'h2, 0); push(7, 32'h22);
    tick(); lsu(1, 1, 4, 32'h4, 0); push(7, 32'h22);
    chk("ov_before", 64'(o_overflow), 0);
    tick(); lsu(0, 0, 0, 0, 0); #1;
    chk("ov_set", 64'(o_overflow), 1);
    chk("ov_alu_rdy_drain", 64'(o_alu_ready), 0); push(1, 32'h1);
    tick(); push(2, 32'h2);
    tick(); push(7, 32'h22);
    tick(); alu(0, 0, 0); tick(); tick();
    chk("ov_sticky", 64'(o_overflow), 1);
    chk("ov_empty", 64'(o_busy), 0);

    // x0 load and stores
    lsu(1, 1, 0, 32'h55, 0);
    tick(); lsu(1, 0, 8, 32'h66, 0);
    chk("x0_busy", 64'(o_busy), 0);
    tick(); lsu(1, 0, 8, 32'h77, 1);
    chk("st_busy", 64'(o_busy), 0);
    chk("st_no_excp", 64'(o_excp_valid), 0);
    tick(); lsu(0, 0, 0, 0, 0);
    chk("excp_pulse", 64'(o_excp_valid), 1);
    chk("excp_busy", 64'(o_busy), 0);
    tick();
    chk("excp_once", 64'(o_excp_valid), 0);
    tick();

    // Hazard against a pending entry
    lsu(1, 1, 9, 32'h99, 0); push(9, 32'h99);
    tick(); lsu(0, 0, 0, 0, 0);
    i_chk_rs1 = 9; i_chk_rs2 = 0; #1;
    chk("hz_rs1_match", 64'(o_hazard), 1);
    i_chk_rs1 = 0; i_chk_rs2 = 8; #1;
    chk("hz_nomatch", 64'(o_hazard), 0);
    tick(); i_chk_rs1 = 9; #1;
    chk("hz_drained", 64'(o_hazard), 0);
    i_chk_rs1 = 0; i_chk_rs2 = 0;
    tick(); tick();

    // Reset while two entries are pending in LSU priority
    alu(1, 7, 32'h22); lsu(1, 1, 10, 32'hA0, 0); push(7, 32'h22);
    tick(); lsu(1, 1, 11, 32'hB0, 0); push(7, 32'h22);
    tick(); lsu(0, 0, 0, 0, 0); push(7, 32'h22);
    tick(); alu(0, 0, 0); rst = 1;
    chk("rd_busy_pre", 64'(o_busy), 1);
    tick(); rst = 0; alu(1, 12, 32'hC0); #1;
    chk("rd_wen", 64'(o_rf_wen), 0);
    chk("rd_busy", 64'(o_busy), 0);
    chk("rd_lsu_ready", 64'(o_lsu_ready), 1);
    chk("rd_ovf_clr", 64'(o_overflow), 0);
    chk("rd_alu_rdy", 64'(o_alu_ready), 1); push(12, 32'hC0);
    tick(); alu(0, 0, 0);
    chk("rd_alu_write", 64'(o_rf_wen), 1);
    tick(); tick();

    chk("queue_empty", 64'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
